// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter that gives N requesters one at a time exclusive write access to a
// single shared W-bit register, with a hold limit of MAX_HOLD cycles per grant.
module shared_reg_arbiter #(
  parameter int unsigned N        = 4,
  parameter int unsigned W        = 8,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   wr_en,
  input  logic [N*W-1:0] wr_data,
  output logic [N-1:0]   gnt,
  output logic [2:0]     owner,
  output logic [W-1:0]   q,
  output logic           done,
  output logic           timeout
);

  localparam int unsigned HoldW = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(MAX_HOLD - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StRelease} state_e;

  state_e           state_q, state_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic [2:0]       owner_q, owner_d;
  logic [2:0]       ptr_q, ptr_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic [W-1:0]     q_q, q_d;
  logic             done_q, done_d;
  logic             timeout_q, timeout_d;

  logic             found;
  logic [2:0]       sel;
  logic             own_req;
  logic             own_wr;
  logic [W-1:0]     own_data;

  // Rotating priority search; offsets are visited high to low so the lowest offset wins.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int off = N - 1; off >= 0; off--) begin
      for (int j = 0; j < N; j++) begin
        if (j == (int'(ptr_q) + off) % N && req[j]) begin
          found = 1'b1;
          sel   = 3'(j);
        end
      end
    end
  end

  // Only the owner's request, enable and data slice ever reach the register.
  always_comb begin
    own_req  = 1'b0;
    own_wr   = 1'b0;
    own_data = '0;
    for (int i = 0; i < N; i++) begin
      if (owner_q == 3'(i)) begin
        own_req  = req[i];
        own_wr   = wr_en[i];
        own_data = wr_data[i*W +: W];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    q_d       = q_q;
    done_d    = 1'b0;
    timeout_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          gnt_d   = {{(N-1){1'b0}}, 1'b1} << sel;
          owner_d = sel;
          hold_d  = '0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        hold_d = hold_q + 1'b1;
        if (!own_req) begin
          // Voluntary release wins over the limit; the write of this cycle is dropped.
          gnt_d   = '0;
          done_d  = 1'b1;
          state_d = StRelease;
        end else begin
          if (own_wr) q_d = own_data;
          if (hold_q == HoldLast) begin
            gnt_d     = '0;
            done_d    = 1'b1;
            timeout_d = 1'b1;
            state_d   = StRelease;
          end
        end
      end
      StRelease: begin
        ptr_d   = (owner_q == 3'(N - 1)) ? 3'd0 : owner_q + 3'd1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      gnt_q     <= '0;
      owner_q   <= '0;
      ptr_q     <= '0;
      hold_q    <= '0;
      q_q       <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      q_q       <= q_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
    end
  end

  assign gnt     = gnt_q;
  assign owner   = owner_q;
  assign q       = q_q;
  assign done    = done_q;
  assign timeout = timeout_q;

endmodule
